// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D) with
// one outstanding transaction, fair alternation under contention and a watchdog.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_ready,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wstrb,
   output logic                  d_ready,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  if_stall,
   output logic                  d_stall,
   output logic                  bus_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_e;
   typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_e;

   state_e                state_q, state_d;
   grant_e                last_q, last_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;

   logic busy, timeout_hit, done, grant_i, grant_d;

   assign busy        = (state_q != IDLE);
   // The cycle in which the counter would reach TIMEOUT is itself the error completion.
   assign timeout_hit = (TIMEOUT > 0) && busy && !mem_ack && (cnt_q >= CNT_LAST);
   assign done        = busy && (mem_ack || timeout_hit);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      grant_i = 1'b0;
      grant_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (if_req && d_req) begin
               grant_i = (last_q == GRANT_D);
               grant_d = (last_q == GRANT_I);
            end else begin
               grant_i = if_req;
               grant_d = d_req;
            end
         end
         BUSY_I: begin
            if (done) begin
               if (d_req) grant_d = 1'b1;
               else       state_d = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         BUSY_D: begin
            if (done) begin
               if (if_req) grant_i = 1'b1;
               else        state_d = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A grant captures the winner's request fields for the whole transaction.
      if (grant_i) begin
         state_d = BUSY_I;
         last_d  = GRANT_I;
         cnt_d   = '0;
         we_d    = 1'b0;
         addr_d  = if_addr;
         wdata_d = '0;
         wstrb_d = '0;
      end
      if (grant_d) begin
         state_d = BUSY_D;
         last_d  = GRANT_D;
         cnt_d   = '0;
         we_d    = d_we;
         addr_d  = d_addr;
         wdata_d = d_wdata;
         wstrb_d = d_wstrb;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= GRANT_I;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   assign if_ready  = done && (state_q == BUSY_I);
   assign d_ready   = done && (state_q == BUSY_D);
   assign if_rdata  = (if_ready && mem_ack) ? mem_rdata : '0;
   assign d_rdata   = (d_ready && mem_ack) ? mem_rdata : '0;
   assign bus_err   = done && !mem_ack;
   // Stalls are forced low while reset is held, even if a requester is still asserting.
   assign if_stall  = rst && if_req && !if_ready;
   assign d_stall   = rst && d_req && !d_ready;

   assign mem_req   = busy;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter with a transaction-level
// reference model and a simple responding memory.
module tb_mem_port_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        if_stall, d_stall, bus_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner 0 = none, 1 = fetch, 2 = load/store.
   int          m_owner = 0;
   int          m_age   = 0;
   int          m_last  = 1;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic        m_we    = 1'b0;
   logic [3:0]  m_wstrb = '0;

   int done_log[$];
   bit if_rdy_s = 1'b0;
   bit d_rdy_s  = 1'b0;

   // Memory responder knobs: mode 0 random latency, 1 fixed latency, 2 never ack.
   int          resp_mode   = 0;
   int          fixed_lat   = 0;
   int          stray_mode  = 0;
   logic [31:0] fixed_rdata = '0;
   int          resp_wait   = 0;
   int          resp_lat    = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .if_stall(if_stall), .d_stall(d_stall), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic report_timeout(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic model_grant(input int p);
      m_owner = p;
      m_last  = p;
      m_age   = 0;
      if (p == 1) begin
         m_addr = if_addr; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
      end else begin
         m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_wstrb = d_wstrb;
      end
   endtask

   // Compare process: every falling edge, expected outputs from the model, then advance it.
   always @(negedge clk) begin : monitor
      bit busy, tmo, fin, e_ir, e_dr;
      if_rdy_s = if_ready;
      d_rdy_s  = d_ready;
      if (if_ready === 1'b1) done_log.push_back(1);
      if (d_ready === 1'b1)  done_log.push_back(2);
      if (!rst) begin
         check_bit("rst_mem_req", mem_req, 1'b0);
         check_bit("rst_if_ready", if_ready, 1'b0);
         check_bit("rst_d_ready", d_ready, 1'b0);
         check_bit("rst_if_stall", if_stall, 1'b0);
         check_bit("rst_d_stall", d_stall, 1'b0);
         check_bit("rst_bus_err", bus_err, 1'b0);
         check_bit("rst_mem_we", mem_we, 1'b0);
         check_word("rst_mem_addr", mem_addr, 32'h0);
         check_word("rst_mem_wdata", mem_wdata, 32'h0);
         check_word("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
         check_word("rst_if_rdata", if_rdata, 32'h0);
         check_word("rst_d_rdata", d_rdata, 32'h0);
         m_owner = 0; m_age = 0; m_last = 1;
      end else begin
         busy = (m_owner != 0);
         tmo  = busy && !mem_ack && (m_age + 1 >= TO);
         fin  = busy && (mem_ack || tmo);
         e_ir = fin && (m_owner == 1);
         e_dr = fin && (m_owner == 2);
         check_bit("if_ready", if_ready, e_ir);
         check_bit("d_ready", d_ready, e_dr);
         check_bit("bus_err", bus_err, fin && !mem_ack);
         check_bit("if_stall", if_stall, if_req && !e_ir);
         check_bit("d_stall", d_stall, d_req && !e_dr);
         check_bit("mem_req", mem_req, busy);
         if (e_ir) check_word("if_rdata", if_rdata, mem_ack ? mem_rdata : 32'h0);
         if (e_dr) check_word("d_rdata", d_rdata, mem_ack ? mem_rdata : 32'h0);
         if (busy) begin
            check_word("mem_addr", mem_addr, m_addr);
            check_bit("mem_we", mem_we, m_we);
            check_word("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
            if (m_owner == 2) check_word("mem_wdata", mem_wdata, m_wdata);
         end
         if (!busy) begin
            if (if_req && d_req) model_grant((m_last == 1) ? 2 : 1);
            else if (if_req)     model_grant(1);
            else if (d_req)      model_grant(2);
         end else if (fin) begin
            if (m_owner == 1 && d_req)       model_grant(2);
            else if (m_owner == 2 && if_req) model_grant(1);
            else                             m_owner = 0;
         end else begin
            m_age++;
         end
      end
   end

   // Memory responder driven just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!mem_req) begin
            resp_wait = 0;
            resp_lat  = (resp_mode == 1) ? fixed_lat : int'($urandom_range(0, 3));
            mem_ack   = (stray_mode == 1) || (stray_mode == 2 && $urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end else if (resp_mode == 2) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end else if (resp_wait >= resp_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = (resp_mode == 1) ? fixed_rdata : $urandom;
            resp_wait = 0;
            resp_lat  = (resp_mode == 1) ? fixed_lat : int'($urandom_range(0, 3));
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            resp_wait++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      tick();
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((if_req || d_req || mem_req) && k < 100) begin
         tick();
         if (if_rdy_s) if_req = 1'b0;
         if (d_rdy_s)  d_req  = 1'b0;
         k++;
      end
      if (k >= 100) report_timeout(name);
   endtask

   task automatic apply_stimulus();
      int k;
      // Reset and a single fetch acknowledged one cycle after mem_req rises.
      resp_mode = 1; fixed_lat = 1; fixed_rdata = 32'h0010_0093; stray_mode = 0;
      tick(); tick();
      rst = 1'b1;
      @(negedge clk);
      check_bit("t1_reset_mem_req", mem_req, 1'b0);
      tick();
      if_req = 1'b1; if_addr = 32'h0000_0010;
      @(negedge clk);
      check_bit("t1_arb_stall", if_stall, 1'b1);
      check_bit("t1_arb_mem_req", mem_req, 1'b0);
      tick(); @(negedge clk);
      check_bit("t1_mem_req", mem_req, 1'b1);
      check_word("t1_mem_addr", mem_addr, 32'h10);
      check_bit("t1_mem_we", mem_we, 1'b0);
      check_bit("t1_wait_ready", if_ready, 1'b0);
      check_bit("t1_wait_stall", if_stall, 1'b1);
      tick(); @(negedge clk);
      check_bit("t1_ready", if_ready, 1'b1);
      check_word("t1_rdata", if_rdata, 32'h0010_0093);
      check_bit("t1_stall_done", if_stall, 1'b0);
      tick();
      if_req = 1'b0;
      @(negedge clk);
      check_bit("t1_ready_once", if_ready, 1'b0);
      check_bit("t1_idle", mem_req, 1'b0);

      // Contention right after reset: D first, then I back-to-back.
      fixed_lat = 0; fixed_rdata = 32'h1234_5678;
      apply_reset();
      tick();
      if_req = 1'b1; if_addr = 32'h0000_0040;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
      @(negedge clk);
      check_bit("t2_arb_if_stall", if_stall, 1'b1);
      check_bit("t2_arb_d_stall", d_stall, 1'b1);
      tick(); @(negedge clk);
      check_bit("t2_d_mem_req", mem_req, 1'b1);
      check_word("t2_d_addr", mem_addr, 32'h200);
      check_bit("t2_d_ready", d_ready, 1'b1);
      check_bit("t2_i_not_ready", if_ready, 1'b0);
      check_word("t2_d_rdata", d_rdata, 32'h1234_5678);
      tick();
      d_req = 1'b0;
      @(negedge clk);
      check_bit("t2_i_mem_req", mem_req, 1'b1);
      check_word("t2_i_addr", mem_addr, 32'h40);
      check_bit("t2_i_ready", if_ready, 1'b1);
      tick();
      if_req = 1'b0;
      @(negedge clk);
      check_bit("t2_idle", mem_req, 1'b0);

      // Sustained contention with random latencies.
      resp_mode = 0;
      tick();
      done_log.delete();
      if_req = 1'b1; if_addr = $urandom;
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
      d_wdata = $urandom; d_wstrb = 4'($urandom);
      k = 0;
      while (done_log.size() < 6 && k < 200) begin
         tick();
         if (if_rdy_s) if_addr = $urandom;
         if (d_rdy_s) begin
            d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
            d_wdata = $urandom; d_wstrb = 4'($urandom);
         end
         k++;
      end
      if (done_log.size() < 6) report_timeout("t3_six_transactions");
      else for (int i = 0; i < 6; i++)
         check_word($sformatf("t3_order%0d", i), 32'(done_log[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
      drain("t3_drain");

      // Store with fixed two-cycle wait.
      resp_mode = 1; fixed_lat = 2; fixed_rdata = 32'h0;
      tick();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0304;
      d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
      @(negedge clk);
      check_bit("t4_arb_stall", d_stall, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick(); @(negedge clk);
         check_bit("t4_mem_req", mem_req, 1'b1);
         check_bit("t4_mem_we", mem_we, 1'b1);
         check_word("t4_mem_addr", mem_addr, 32'h304);
         check_word("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         check_word("t4_mem_wstrb", 32'(mem_wstrb), 32'h3);
         check_bit("t4_d_ready", d_ready, (c == 2) ? 1'b1 : 1'b0);
      end
      tick();
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check_bit("t4_idle", mem_req, 1'b0);

      // Watchdog: fetch never acknowledged.
      resp_mode = 2;
      tick();
      if_req = 1'b1; if_addr = 32'h0000_0080;
      @(negedge clk);
      for (int c = 1; c <= 8; c++) begin
         tick(); @(negedge clk);
         check_bit("t5_mem_req", mem_req, 1'b1);
         check_bit("t5_if_ready", if_ready, (c == 8) ? 1'b1 : 1'b0);
         check_bit("t5_bus_err", bus_err, (c == 8) ? 1'b1 : 1'b0);
         if (c == 8) check_word("t5_if_rdata", if_rdata, 32'h0);
      end
      tick();
      if_req = 1'b0;
      @(negedge clk);
      check_bit("t5_mem_req_drop", mem_req, 1'b0);

      // Reset while BUSY_D, then a simultaneous request goes to D.
      tick();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
      @(negedge clk);
      tick(); @(negedge clk);
      check_bit("t6_busy_d", mem_req, 1'b1);
      tick();
      rst = 1'b0; d_req = 1'b0;
      #1;
      check_bit("t6_async_drop", mem_req, 1'b0);
      check_bit("t6_no_ready", d_ready, 1'b0);
      resp_mode = 1; fixed_lat = 0; fixed_rdata = 32'hCAFE_0001;
      tick();
      rst = 1'b1;
      tick();
      if_req = 1'b1; if_addr = 32'h0000_0044;
      d_req = 1'b1; d_addr = 32'h0000_0108;
      @(negedge clk);
      tick(); @(negedge clk);
      check_word("t6_d_first_addr", mem_addr, 32'h108);
      check_bit("t6_d_ready", d_ready, 1'b1);
      check_bit("t6_i_wait", if_ready, 1'b0);
      tick();
      d_req = 1'b0;
      @(negedge clk);
      check_word("t6_i_addr", mem_addr, 32'h44);
      check_bit("t6_i_ready", if_ready, 1'b1);
      tick();
      if_req = 1'b0;

      // Stray acknowledges while idle.
      stray_mode = 1;
      for (int c = 0; c < 4; c++) begin
         tick(); @(negedge clk);
         check_bit("t7_stray_if", if_ready, 1'b0);
         check_bit("t7_stray_d", d_ready, 1'b0);
      end
      stray_mode = 0;

      // Randomised traffic, including a no-ack window and a reset pulse.
      resp_mode = 0; stray_mode = 2;
      for (int c = 0; c < 600; c++) begin
         tick();
         if (c == 300) resp_mode = 2;
         if (c == 340) resp_mode = 0;
         if (c == 450) begin rst = 1'b0; if_req = 1'b0; d_req = 1'b0; end
         if (c == 452) rst = 1'b1;
         if (rst) begin
            if (!if_req) begin
               if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            end else if (if_rdy_s) begin
               if ($urandom_range(0, 1) == 0) if_req = 1'b0;
               else                           if_addr = $urandom;
            end
            if (!d_req || d_rdy_s) begin
               if (d_req && $urandom_range(0, 1) == 0) d_req = 1'b0;
               else if (d_req || $urandom_range(0, 2) == 0) begin
                  d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                  d_wdata = $urandom; d_wstrb = 4'($urandom);
               end
            end
         end
      end
      stray_mode = 0;
      drain("random_drain");
      tick();
   endtask

   initial begin
      apply_stimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] global time limit reached");
   end

endmodule
